// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared state encodings and defaults for the fetch PC generator
package pc_gen_pkg;

  typedef enum logic [1:0] {
    PCG_BOOT = 2'd0,
    PCG_RUN  = 2'd1,
    PCG_HALT = 2'd2
  } pcg_state_e;

  localparam int unsigned        PCG_ADDR_W     = 32;
  localparam logic [31:0]        PCG_RESET_ADDR = 32'h0;
  localparam logic [PCG_ADDR_W-1:0] CpuResetAddr = PCG_RESET_ADDR;

  localparam int unsigned PCG_HOLD_W      = 3;
  localparam int unsigned PCG_HOLD_NONE   = 0;
  localparam int unsigned PCG_HOLD_PC_LVL = 1;

endpackage

// File: rtl/pc_redirect_buf.sv
// rtl/pc_redirect_buf.sv - pending redirect target register (set/overwrite/clear, valid flag)
module pc_redirect_buf #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set,
  input  logic              clr,
  input  logic [ADDR_W-1:0] set_addr,
  output logic              valid,
  output logic [ADDR_W-1:0] addr
);

  // Clear wins over set: the consumer loads any same-cycle jump directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (set) begin
      valid <= 1'b1;
      addr  <= set_addr;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC generator with boot delay, debug halt and pending redirect
// Optional macro PC_MISALIGN_CHK_EN: reject jump targets not aligned to STEP.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned        ADDR_W      = PCG_ADDR_W,
  parameter logic [ADDR_W-1:0]  RESET_ADDR  = ADDR_W'(CpuResetAddr),
  parameter int unsigned        HOLD_W      = PCG_HOLD_W,
  parameter int unsigned        HOLD_PC_LVL = PCG_HOLD_PC_LVL,
  parameter int unsigned        STEP        = 4,
  parameter int unsigned        BOOT_DELAY  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jtag_reset_i,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic [HOLD_W-1:0] hold_flag_i,
  input  logic              stall_i,
  input  logic              halt_req_i,
  input  logic              resume_req_i,
  input  logic              fetch_ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_valid_o,
  output logic              halted_o,
  output logic              redirect_pending_o,
  output logic              misalign_o
);

  localparam int unsigned CW = (BOOT_DELAY > 0) ? $clog2(BOOT_DELAY + 1) : 1;
  localparam logic [CW:0] BOOT_END = (CW+1)'(BOOT_DELAY);

  pcg_state_e        state_q, state_d;
  logic [CW-1:0]     boot_cnt_q, boot_cnt_d;
  logic [CW:0]       cnt_inc;
  logic              boot_done;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              any_rst;
  logic              jump_ok, jump_bad;
  logic              run_ok;
  logic              pend_set, pend_clr, pend_valid;
  logic [ADDR_W-1:0] pend_addr;

  assign any_rst   = rst | jtag_reset_i;
  assign cnt_inc   = {1'b0, boot_cnt_q} + 1'b1;
  assign boot_done = (cnt_inc >= BOOT_END);
  assign run_ok    = ~stall_i & (hold_flag_i < HOLD_W'(HOLD_PC_LVL));

`ifdef PC_MISALIGN_CHK_EN
  localparam int unsigned LSB_W = $clog2(STEP);
  logic misalign_q;

  assign jump_bad = jump_flag_i & (jump_addr_i[LSB_W-1:0] != '0);

  always_ff @(posedge clk) begin
    if (any_rst) misalign_q <= 1'b0;
    else         misalign_q <= jump_bad;
  end
  assign misalign_o = misalign_q;
`else
  assign jump_bad   = 1'b0;
  assign misalign_o = 1'b0;
`endif

  assign jump_ok = jump_flag_i & ~jump_bad;

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pc_d       = pc_q;
    pend_set   = 1'b0;
    pend_clr   = 1'b0;
    pc_valid_o = 1'b0;
    case (state_q)
      PCG_BOOT: begin
        boot_cnt_d = cnt_inc[CW-1:0];
        pend_set   = jump_ok & ~boot_done;
        if (boot_done) begin
          state_d  = PCG_RUN;
          pend_clr = 1'b1;
          if (jump_ok)         pc_d = jump_addr_i;
          else if (pend_valid) pc_d = pend_addr;
        end
      end
      PCG_RUN: begin
        pc_valid_o = run_ok;
        // A rejected (misaligned) jump still outranks the increment.
        if (jump_ok)                                  pc_d = jump_addr_i;
        else if (!jump_bad && run_ok && fetch_ready_i) pc_d = pc_q + ADDR_W'(STEP);
        if (halt_req_i) state_d = PCG_HALT;
      end
      PCG_HALT: begin
        if (resume_req_i) begin
          state_d  = PCG_RUN;
          pend_clr = 1'b1;
          if (jump_ok)         pc_d = jump_addr_i;
          else if (pend_valid) pc_d = pend_addr;
        end else begin
          pend_set = jump_ok;
        end
      end
      default: state_d = PCG_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (any_rst) begin
      state_q    <= PCG_BOOT;
      boot_cnt_q <= '0;
      pc_q       <= RESET_ADDR;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_q       <= pc_d;
    end
  end

  pc_redirect_buf #(.ADDR_W(ADDR_W)) u_redirect_buf (
    .clk      (clk),
    .rst      (any_rst),
    .set      (pend_set),
    .clr      (pend_clr),
    .set_addr (jump_addr_i),
    .valid    (pend_valid),
    .addr     (pend_addr)
  );

  assign pc_o               = pc_q;
  assign halted_o           = (state_q == PCG_HALT);
  assign redirect_pending_o = pend_valid;

endmodule
